iter_shift_unit: RTL



---
 rtl/iter_shift_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multi-cycle shifter with valid/ready handshakes on both sides.
// Shifts by up to STEP bit positions per clock in one of four modes:
// logical left, logical right, arithmetic right, rotate left.
// Optional feature macro ITER_SHIFT_ROTATE_EN: when defined, shift_mode 2'b11
// rotates left; when undefined, the rotate datapath is not built and 2'b11
// behaves as a logical left shift.
module iter_shift_unit #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [$clog2(WIDTH)-1:0] shift_amount,
    input  logic [1:0]               shift_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         result,
    output logic                     busy
);

    localparam int AW = $clog2(WIDTH);
    localparam logic [AW-1:0] STEP_C = AW'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [1:0]        mode_q, mode_d;
    logic [AW-1:0]     rem_q, rem_d;
    logic [AW-1:0]     step_k;

    // One k-bit step in the given mode; k is never larger than WIDTH-1.
    // Arithmetic right re-reads the sign from the working register MSB, so
    // the sign survives every step.
    function automatic logic [WIDTH-1:0] step_shift(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m,
        input logic [AW-1:0]    k
    );
        logic signed [WIDTH-1:0] ds;
        ds = d;
        case (m)
            2'b01:   return d >> k;
            2'b10:   return ds >>> k;
`ifdef ITER_SHIFT_ROTATE_EN
            2'b11:   return (d << k) | (d >> (WIDTH - int'(k)));
`else
            2'b11:   return d << k;
`endif
            default: return d << k;
        endcase
    endfunction

    // Step size this cycle: the smaller of STEP and the remaining distance.
    assign step_k = (rem_q < STEP_C) ? rem_q : STEP_C;

    // Next-state and next-register logic.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = data_in;
                    mode_d  = shift_mode;
                    rem_d   = shift_amount;
                    state_d = (shift_amount != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                data_d = step_shift(data_q, mode_q, step_k);
                rem_d  = rem_q - step_k;
                if (rem_q == step_k) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and working registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            mode_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
        end
    end

    // Outputs decode the registered state only, so no input-to-output path exists.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = data_q;

endmodule
